fifo_width_down_reader: RTL
===========================

// Module: fifo_width_down_reader
// PURPOSE
//  Reader end of the ENQ/FULL_N/DEQ/EMPTY_N FIFO protocol.
//  - Drains DATA_WIDTH-bit words from an upstream FIFO (consumes EMPTY_N/D_IN, drives DEQ).
//  - Serialises each word into RATIO = DATA_WIDTH/CHUNK_WIDTH chunks, sent LSB chunk first.
//  - Pushes the chunks into a downstream FIFO (consumes FULL_N, drives ENQ/D_OUT).
//  - Sits between a wide datapath FIFO and a narrow link/port FIFO.
// PARAMETERS
//  DATA_WIDTH   32  upstream word width
//  CHUNK_WIDTH  8   downstream chunk width; DATA_WIDTH % CHUNK_WIDTH == 0, RATIO >= 2
// PORTS
//  CLK      in   1            clock; all state on posedge
//  RST      in   1            reset, synchronous, active-low
//  CLR      in   1            sync clear: abandon word in flight
//  EMPTY_N  in   1            upstream FIFO has data
//  D_IN     in   DATA_WIDTH   upstream FIFO head; valid when EMPTY_N=1
//  DEQ      out  1            dequeue upstream head this cycle
//  FULL_N   in   1            downstream FIFO can accept
//  ENQ      out  1            enqueue D_OUT downstream this cycle
//  D_OUT    out  CHUNK_WIDTH  current chunk
//  LAST     out  1            D_OUT is the final chunk of its word
//  BUSY     out  1            a word is held (registered)
// BEHAVIOUR
//  State
//  - busy (1b); idx (clog2(RATIO)b); shreg (DATA_WIDTH).
//  - States: IDLE (busy=0) and SEND (busy=1).
//  Combinational outputs
//  - D_OUT = shreg[CHUNK_WIDTH-1:0]
//  - LAST  = busy && idx==RATIO-1
//  - ENQ   = RST && !CLR && busy && FULL_N
//  - DEQ   = RST && !CLR && EMPTY_N && (!busy || (LAST && FULL_N))
//  - DEQ depends combinationally on FULL_N; ENQ does not depend on EMPTY_N.
//  Reset (RST=0 at posedge)
//  - busy=0, idx=0, shreg=0.
//  - While RST=0: ENQ=0, DEQ=0, LAST=0, BUSY=0, D_OUT=0.
//  Transitions (priority order: RST, CLR, then the rest)
//  - CLR: busy<=0, idx<=0, shreg unchanged. Partial word dropped; upstream head not dequeued.
//  - DEQ: shreg<=D_IN, idx<=0, busy<=1 (IDLE->SEND, or SEND->SEND on LAST).
//  - ENQ && !LAST: shreg<=shreg>>CHUNK_WIDTH, idx<=idx+1.
//  - ENQ && LAST && !DEQ: busy<=0, idx<=0 (SEND->IDLE).
//  - FULL_N=0 while SEND: all state held; D_OUT/LAST stable until accepted.
//  Timing
//  - Latency: word dequeued at edge t -> chunk 0 ENQ earliest in cycle t+1.
//  - Throughput: 1 chunk/cycle sustained; back-to-back words have no bubble
//    (next DEQ coincides with the accepted LAST chunk).
//  - idx never exceeds RATIO-1; no wrap beyond LAST.
//  Assertions (sim-only, translate_off): $display warning if
//  - DEQ && !EMPTY_N
//  - ENQ && !FULL_N
// TESTING
//  1 Reset: RST=0 for 3 cycles, EMPTY_N=1, FULL_N=1
//    -> DEQ=ENQ=BUSY=0 throughout; DEQ=1 in first cycle with RST=1.
//  2 Single word D_IN=32'hDDCCBBAA, FULL_N=1
//    -> one DEQ; ENQ on 4 consecutive cycles, D_OUT=AA,BB,CC,DD; LAST only with DD; BUSY=0 after.
//  3 Back-to-back words 32'h04030201, 32'h08070605, EMPTY_N held 1
//    -> 8 consecutive ENQs, D_OUT=01..08; second DEQ in the cycle D_OUT=04, LAST=1.
//  4 Backpressure: FULL_N=0 for 3 cycles while D_OUT=CC
//    -> ENQ=0, D_OUT holds CC, DEQ=0; resumes CC then DD.
//  5 CLR pulse after chunks AA,BB accepted
//    -> ENQ=DEQ=0 in CLR cycle, BUSY=0 next cycle; next word restarts at its chunk 0.
//  6 DATA_WIDTH=16, CHUNK_WIDTH=4, D_IN=16'hA5C3; RST=0 mid-word
//    -> chunks 3,C,5,A when not interrupted; RST pulse after 2 chunks drops the word; next word starts at chunk 0.

Source files
------------

// File: rtl/fifo_width_down_reader.sv
// fifo_width_down_reader
// Drains wide words from an upstream ENQ/FULL_N/DEQ/EMPTY_N FIFO and pushes
// them, LSB chunk first, into a narrower downstream FIFO. The next word is
// dequeued in the same cycle the last chunk of the current word is accepted,
// so back-to-back words stream at one chunk per cycle with no bubble.
//
// state | meaning
// IDLE  | no word held; dequeue as soon as upstream has data
// SEND  | word held in r_shreg; r_idx counts chunks already accepted
module fifo_width_down_reader #(
   parameter int DATA_WIDTH  = 32,
   parameter int CHUNK_WIDTH = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   CLR,
   input  logic                   EMPTY_N,
   input  logic [DATA_WIDTH-1:0]  D_IN,
   output logic                   DEQ,
   input  logic                   FULL_N,
   output logic                   ENQ,
   output logic [CHUNK_WIDTH-1:0] D_OUT,
   output logic                   LAST,
   output logic                   BUSY
);

   localparam int RATIO = DATA_WIDTH / CHUNK_WIDTH;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [DATA_WIDTH-1:0] r_shreg;

   logic w_busy;
   logic w_last;
   logic w_enq;
   logic w_deq;

   // Handshake decode; DEQ looks through FULL_N so the next word can be
   // taken in the same cycle the final chunk is accepted.
   always_comb begin
      w_busy = RST && (r_state == SEND);
      w_last = w_busy && (r_idx == LAST_IDX);
      w_enq  = RST && !CLR && w_busy && FULL_N;
      w_deq  = RST && !CLR && EMPTY_N && (!w_busy || (w_last && FULL_N));
   end

   assign DEQ   = w_deq;
   assign ENQ   = w_enq;
   assign LAST  = w_last;
   assign BUSY  = w_busy;
   assign D_OUT = RST ? r_shreg[CHUNK_WIDTH-1:0] : '0;

   // Word/chunk sequencing: reset, clear, load, shift, release.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_shreg <= '0;
      end else if (CLR) begin
         // Partial word is dropped; shift register content is left as is.
         r_state <= IDLE;
         r_idx   <= '0;
      end else if (w_deq) begin
         r_state <= SEND;
         r_idx   <= '0;
         r_shreg <= D_IN;
      end else if (w_enq && !w_last) begin
         r_idx   <= r_idx + 1'b1;
         r_shreg <= r_shreg >> CHUNK_WIDTH;
      end else if (w_enq && w_last) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end
   end

endmodule
